// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if: request, counter feedback and status bundle for the counter sequencer
interface counter_seq_ctrl_if;
  logic       start;
  logic       dir;
  logic [3:0] start_val;
  logic [4:0] steps;
  logic       abort;
  logic [3:0] qn;
  logic       co;
  logic       load;
  logic       en;
  logic       updn;
  logic [3:0] d;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] wraps;
  modport master(output start, dir, start_val, steps, abort, qn, co,
                 input load, en, updn, d, busy, done, err, wraps);
  modport slave(input start, dir, start_val, steps, abort, qn, co,
                output load, en, updn, d, busy, done, err, wraps);
endinterface

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: drives an external up/down counter through load, count and end-value check
module counter_seq_ctrl (
  input logic CLK,
  input logic MR,
  counter_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOADST, RUN, CHECK, DONE} state_t;
  state_t     state, nxt;
  logic       dir_q, en_q, err_q;
  logic [3:0] sv_q, exp_v;
  logic [4:0] steps_q, rem;
  logic [1:0] wraps_q;
  assign exp_v = dir_q ? sv_q - steps_q[3:0] : sv_q + steps_q[3:0];
  assign bus.load  = state != LOADST;
  assign bus.en    = state == RUN;
  assign bus.busy  = state != IDLE;
  assign bus.done  = state == DONE;
  assign bus.updn  = dir_q;
  assign bus.d     = sv_q;
  assign bus.err   = err_q;
  assign bus.wraps = wraps_q;
  // state register, latched parameters, step countdown, wrap count and end-value check
  always_ff @(posedge CLK) begin
    if (MR) begin
      state   <= IDLE;
      dir_q   <= 1'b0;
      sv_q    <= 4'd0;
      steps_q <= 5'd0;
      rem     <= 5'd0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      wraps_q <= 2'd0;
    end else begin
      state <= nxt;
      en_q  <= bus.en;
      if (state == IDLE && bus.start) begin
        dir_q   <= bus.dir;
        sv_q    <= bus.start_val;
        steps_q <= bus.steps;
        rem     <= bus.steps;
        err_q   <= 1'b0;
        wraps_q <= 2'd0;
      end
      if (state == RUN) rem <= rem - 5'd1;
      if ((state == RUN || state == CHECK) && en_q && bus.co && wraps_q != 2'd3)
        wraps_q <= wraps_q + 2'd1;
      if (state == CHECK && !bus.abort) err_q <= bus.qn != exp_v;
    end
  end
  // next-state decode; abort leaves any active state straight to IDLE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? LOADST : IDLE;
      LOADST:  nxt = bus.abort ? IDLE : (steps_q != 5'd0 ? RUN : CHECK);
      RUN:     nxt = bus.abort ? IDLE : (rem == 5'd1 ? CHECK : RUN);
      CHECK:   nxt = bus.abort ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed checks of the sequencer against an up/down counter model
module tb_counter_seq_ctrl;
  logic       CLK = 1'b0;
  logic       MR  = 1'b1;
  logic       stuck = 1'b0;
  logic [3:0] qn_m = 4'd0;
  logic       co_m = 1'b0;
  int         tests = 0;
  int         fails = 0;
  counter_seq_ctrl_if bif();
  counter_seq_ctrl dut (.CLK(CLK), .MR(MR), .bus(bif));
  always #5 CLK = ~CLK;
  assign bif.qn = qn_m;
  assign bif.co = co_m;
  // downstream counter: sync active-low load, registered one-cycle carry/borrow pulse after a wrapping count
  always @(posedge CLK) begin
    if (!bif.load) begin
      qn_m <= bif.d;
      co_m <= 1'b0;
    end else if (bif.en && !stuck) begin
      qn_m <= bif.updn ? qn_m - 4'd1 : qn_m + 4'd1;
      co_m <= bif.updn ? (qn_m == 4'd0) : (qn_m == 4'd15);
    end else
      co_m <= 1'b0;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run_seq(input string tag, input logic [3:0] sv, input logic dir, input logic [4:0] st,
                         output int lat, output int en_cnt, output int ld_cnt, output logic [3:0] d_ld);
    @(negedge CLK);
    bif.start_val = sv;
    bif.dir = dir;
    bif.steps = st;
    bif.start = 1'b1;
    lat = 0;
    en_cnt = 0;
    ld_cnt = 0;
    d_ld = 4'd0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(posedge CLK);
      #1;
      bif.start = 1'b0;
      if (!bif.load) begin
        ld_cnt++;
        d_ld = bif.d;
      end
      if (bif.en) en_cnt++;
      if (bif.done) lat = n;
    end
    if (lat == 0) check({tag, " timeout"}, 0, 1);
  endtask
  task automatic to_idle();
    @(posedge CLK);
    #1;
  endtask
  int lat, en_cnt, ld_cnt, dn;
  logic [3:0] d_ld;
  initial begin
    bif.start = 1'b1;
    bif.dir = 1'b1;
    bif.start_val = 4'd11;
    bif.steps = 5'd6;
    bif.abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      #1;
      check("rst load", bif.load, 1);
      check("rst en", bif.en, 0);
      check("rst updn", bif.updn, 0);
      check("rst d", bif.d, 0);
      check("rst busy", bif.busy, 0);
      check("rst done", bif.done, 0);
      check("rst err", bif.err, 0);
      check("rst wraps", bif.wraps, 0);
    end
    bif.start = 1'b0;
    MR = 1'b0;
    run_seq("up3x4", 4'd3, 1'b0, 5'd4, lat, en_cnt, ld_cnt, d_ld);
    check("up3x4 lat", lat, 7);
    check("up3x4 en", en_cnt, 4);
    check("up3x4 ld", ld_cnt, 1);
    check("up3x4 d", d_ld, 3);
    check("up3x4 qn", bif.qn, 7);
    check("up3x4 err", bif.err, 0);
    check("up3x4 wraps", bif.wraps, 0);
    to_idle();
    check("up3x4 idle", bif.busy, 0);
    run_seq("up14x3", 4'd14, 1'b0, 5'd3, lat, en_cnt, ld_cnt, d_ld);
    check("up14x3 lat", lat, 6);
    check("up14x3 qn", bif.qn, 1);
    check("up14x3 wraps", bif.wraps, 1);
    check("up14x3 err", bif.err, 0);
    to_idle();
    run_seq("dn0x17", 4'd0, 1'b1, 5'd17, lat, en_cnt, ld_cnt, d_ld);
    check("dn0x17 lat", lat, 20);
    check("dn0x17 en", en_cnt, 17);
    check("dn0x17 qn", bif.qn, 15);
    check("dn0x17 wraps", bif.wraps, 2);
    check("dn0x17 err", bif.err, 0);
    to_idle();
    check("dn0x17 wraps hold", bif.wraps, 2);
    check("dn0x17 updn hold", bif.updn, 1);
    run_seq("zero9", 4'd9, 1'b0, 5'd0, lat, en_cnt, ld_cnt, d_ld);
    check("zero9 lat", lat, 3);
    check("zero9 en", en_cnt, 0);
    check("zero9 qn", bif.qn, 9);
    check("zero9 wraps", bif.wraps, 0);
    check("zero9 err", bif.err, 0);
    to_idle();
    @(negedge CLK);
    bif.start_val = 4'd2;
    bif.dir = 1'b0;
    bif.steps = 5'd8;
    bif.start = 1'b1;
    to_idle();
    bif.start = 1'b0;
    to_idle();
    check("abort run1 en", bif.en, 1);
    bif.start = 1'b1;
    bif.start_val = 4'd12;
    bif.dir = 1'b1;
    to_idle();
    bif.start = 1'b0;
    check("midstart d", bif.d, 2);
    check("midstart updn", bif.updn, 0);
    check("midstart en", bif.en, 1);
    bif.abort = 1'b1;
    to_idle();
    bif.abort = 1'b0;
    check("abort en", bif.en, 0);
    check("abort busy", bif.busy, 0);
    check("abort load", bif.load, 1);
    check("abort qn", bif.qn, 4);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      to_idle();
      if (bif.done || bif.busy) dn++;
    end
    check("abort no done", dn, 0);
    @(negedge CLK);
    bif.start_val = 4'd6;
    bif.dir = 1'b0;
    bif.steps = 5'd5;
    bif.start = 1'b1;
    bif.abort = 1'b1;
    to_idle();
    bif.start = 1'b0;
    bif.abort = 1'b0;
    check("start wins busy", bif.busy, 1);
    check("start wins load", bif.load, 0);
    to_idle();
    to_idle();
    MR = 1'b1;
    to_idle();
    MR = 1'b0;
    check("mr busy", bif.busy, 0);
    check("mr en", bif.en, 0);
    check("mr d", bif.d, 0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      to_idle();
      if (bif.done || bif.busy) dn++;
    end
    check("mr no done", dn, 0);
    stuck = 1'b1;
    run_seq("stuck", 4'd5, 1'b0, 5'd2, lat, en_cnt, ld_cnt, d_ld);
    check("stuck lat", lat, 5);
    check("stuck qn", bif.qn, 5);
    check("stuck err", bif.err, 1);
    to_idle();
    check("stuck err hold", bif.err, 1);
    stuck = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 MR  in  1  reset, synchronous, active-high.
REQ-004 START  in  1  request a sequence; sampled only in IDLE.
REQ-005 DIR  in  1  0 = count up, 1 = count down; latched on START.
REQ-006 START_VAL  in  4  value loaded into counter; latched on START.
REQ-007 STEPS  in  5  number of count steps, 0..31; latched on START.
REQ-008 ABORT  in  1  cancel sequence in LOADST/RUN/CHECK.
REQ-009 QN  in  4  counter value fed back from downstream up/down counter.
REQ-010 CO  in  1  counter carry/borrow fed back from downstream counter.
REQ-011 LOAD  out  1  counter load, active-low.
REQ-012 EN  out  1  counter count enable.
REQ-013 UPDN  out  1  counter direction (0 up, 1 down).
REQ-014 D  out  4  counter parallel-load data.
REQ-015 BUSY  out  1  high in any state except IDLE.
REQ-016 DONE  out  1  one-cycle completion pulse.
REQ-017 ERR  out  1  end-value mismatch flag, valid with DONE.
REQ-018 WRAPS  out  2  number of wraps observed, valid with DONE.

Function
REQ-019 All outputs SHALL be registered/Moore-decoded from state; no combinational input-to-output paths.
REQ-020 States: IDLE, LOADST, RUN, CHECK, DONE.
REQ-021 IDLE: LOAD=1, EN=0; START=1 -> latch DIR/START_VAL/STEPS, clear ERR/WRAPS, go LOADST.
REQ-022 LOADST (exactly 1 cycle): LOAD=0, D=latched START_VAL, EN=0; next RUN if STEPS>0, else CHECK.
REQ-023 RUN: EN=1, UPDN=latched DIR, LOAD=1; remaining-step counter decrements each cycle; leaves to CHECK after exactly STEPS cycles.
REQ-024 CHECK (1 cycle): EN=0; at its closing edge ERR <= (QN != expected), expected = (START_VAL + STEPS) mod 16 when up, (START_VAL - STEPS) mod 16 when down.
REQ-025 Wrap count: at every edge in RUN or CHECK where EN was 1 in the previous cycle and CO=1, WRAPS increments; 2-bit, saturates at 3.
REQ-026 DONE state (1 cycle): DONE=1, then IDLE; ERR and WRAPS hold until next accepted START.
REQ-027 Latency: START-sampling edge to DONE-high = STEPS+3 edges (LOADST, RUN x STEPS, CHECK, then DONE).
REQ-028 D SHALL hold latched START_VAL while BUSY; UPDN holds latched DIR while BUSY.
REQ-029 START while BUSY SHALL be ignored; parameter inputs changing while BUSY have no effect.
REQ-030 ABORT in LOADST/RUN/CHECK -> IDLE at next edge, EN=0 and LOAD=1 next cycle, no DONE, ERR/WRAPS hold partial values; ABORT in IDLE/DONE ignored.
REQ-031 ABORT and START same cycle in IDLE: START wins.

Reset
REQ-032 MR=1 at an edge -> IDLE; LOAD=1, EN=0, UPDN=0, D=0, BUSY=0, DONE=0, ERR=0, WRAPS=0.
REQ-033 MR mid-sequence SHALL abandon the sequence with no DONE pulse; MR overrides START and ABORT.

Verification (bench connects the up/down counter model to LOAD/EN/UPDN/D/QN/CO)
REQ-034 MR=1 for 2 cycles with START=1 -> all outputs at REQ-032 values, BUSY stays 0.
REQ-035 START_VAL=3, DIR=0, STEPS=4 -> LOAD low 1 cycle with D=3, EN high 4 cycles, DONE 7 edges after START edge, QN=7, ERR=0, WRAPS=0.
REQ-036 START_VAL=14, DIR=0, STEPS=3 -> QN=1, WRAPS=1, ERR=0; START_VAL=0, DIR=1, STEPS=17 -> QN=15, WRAPS=2, ERR=0.
REQ-037 STEPS=0, START_VAL=9 -> EN never high, DONE 3 edges after START edge, QN=9, WRAPS=0, ERR=0.
REQ-038 ABORT after 2 RUN cycles of an 8-step sequence -> EN low next cycle, BUSY 0, no DONE; a START pulse mid-run is ignored.
REQ-039 Counter model forced to ignore EN (QN stuck at 5), START_VAL=5, STEPS=2, up -> DONE with ERR=1.
